// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Issues a stored program to a core one word at a time. Supports
//            single-step (button driven) and free-run modes. Holds the core
//            in reset for a fixed number of cycles after reset release. Shows
//            the core result and the issue count on 7-segment digits.
// Ports    : clk, rst (async, active-low)
//            mode (0 = step, 1 = run), step (async button), start (pulse)
//            prog_len   - instruction count, sampled at start
//            prog_we/prog_addr/prog_data - program-store write port
//            instr/instr_valid/instr_ready - issue handshake to the core
//            core_rst   - active-high reset to the core
//            pc/busy/done - issue count and status
//            alu_in     - core result; seg/seg_pc - active-low hex digits
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
  parameter int INSTR_W  = 16,
  parameter int DEPTH    = 32,
  parameter int DATA_W   = 16,
  parameter int HOLD_CYC = 4,
  localparam int AW      = $clog2(DEPTH),
  localparam int ND      = DATA_W / 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                step,
  input  logic                start,
  input  logic [AW:0]         prog_len,
  input  logic                prog_we,
  input  logic [AW-1:0]       prog_addr,
  input  logic [INSTR_W-1:0]  prog_data,
  output logic [INSTR_W-1:0]  instr,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic                core_rst,
  output logic [AW:0]         pc,
  output logic                busy,
  output logic                done,
  input  logic [DATA_W-1:0]   alu_in,
  output logic [7*ND-1:0]     seg,
  output logic [6:0]          seg_pc
);

  localparam int           CW          = $clog2(HOLD_CYC + 1);
  localparam logic [CW-1:0] c_HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [AW:0]   c_DEPTH_LEN = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_IDLE      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_STEP = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_hold_cnt;
  logic [AW:0]         r_pc;
  logic [AW:0]         r_len;
  logic                r_core_rst;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_step_s1;
  logic                r_step_s2;
  logic                r_step_s3;
  logic [INSTR_W-1:0]  r_mem [DEPTH];

  logic [AW:0]         w_len_clamped;
  logic [AW:0]         w_pc_inc;
  logic                w_hs;
  logic                w_step_rise;
  logic                w_start_ok;
  logic                w_wr_ok;
  logic [3:0]          w_pc_nib;

  assign w_len_clamped = (prog_len > c_DEPTH_LEN) ? c_DEPTH_LEN : prog_len;
  assign w_pc_inc      = r_pc + 1'b1;
  assign w_hs          = (r_state == S_ISSUE) && instr_ready;
  // Third flop only serves the edge detector, giving a 3-cycle step latency.
  assign w_step_rise   = r_step_s2 && !r_step_s3;
  assign w_start_ok    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  // Store is frozen while a run is active so the issued word cannot change.
  assign w_wr_ok       = (r_state == S_HOLD) || (r_state == S_IDLE) ||
                         (r_state == S_DONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HOLD:      if (r_hold_cnt == c_HOLD_LAST) w_next = S_IDLE;
      S_IDLE,
      S_DONE:      if (start) begin
                     if (w_len_clamped == '0) w_next = S_DONE;
                     else                     w_next = mode ? S_ISSUE : S_WAIT_STEP;
                   end
      S_ISSUE:     if (instr_ready) begin
                     if (w_pc_inc == r_len) w_next = S_DONE;
                     else                   w_next = mode ? S_ISSUE : S_WAIT_STEP;
                   end
      S_WAIT_STEP: if (mode || w_step_rise) w_next = S_ISSUE;
      default:     w_next = S_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_HOLD;
      r_hold_cnt <= '0;
      r_pc       <= '0;
      r_len      <= '0;
      r_core_rst <= 1'b1;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_step_s1  <= 1'b0;
      r_step_s2  <= 1'b0;
      r_step_s3  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_step_s1  <= step;
      r_step_s2  <= r_step_s1;
      r_step_s3  <= r_step_s2;
      if (r_state == S_HOLD && w_next == S_HOLD) r_hold_cnt <= r_hold_cnt + 1'b1;
      if (w_start_ok) begin
        r_len <= w_len_clamped;
        r_pc  <= '0;
      end else if (w_hs) begin
        r_pc  <= w_pc_inc;
      end
      // Outputs are registered from the next state so they line up with it.
      r_core_rst <= (w_next == S_HOLD);
      r_valid    <= (w_next == S_ISSUE);
      r_busy     <= (w_next == S_ISSUE) || (w_next == S_WAIT_STEP);
      r_done     <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we && w_wr_ok) r_mem[prog_addr] <= prog_data;
  end

  assign instr       = r_valid ? r_mem[r_pc[AW-1:0]] : '0;
  assign instr_valid = r_valid;
  assign core_rst    = r_core_rst;
  assign pc          = r_pc;
  assign busy        = r_busy;
  assign done        = r_done;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] lit;  // gfedcba, 1 = segment on
    case (n)
      4'h0:    lit = 7'b0111111;
      4'h1:    lit = 7'b0000110;
      4'h2:    lit = 7'b1011011;
      4'h3:    lit = 7'b1001111;
      4'h4:    lit = 7'b1100110;
      4'h5:    lit = 7'b1101101;
      4'h6:    lit = 7'b1111101;
      4'h7:    lit = 7'b0000111;
      4'h8:    lit = 7'b1111111;
      4'h9:    lit = 7'b1101111;
      4'hA:    lit = 7'b1110111;
      4'hB:    lit = 7'b1111100;
      4'hC:    lit = 7'b0111001;
      4'hD:    lit = 7'b1011110;
      4'hE:    lit = 7'b1111001;
      default: lit = 7'b1110001;
    endcase
    return ~lit;
  endfunction

  for (genvar k = 0; k < ND; k++) begin : g_digit
    assign seg[7*k +: 7] = hex7(alu_in[4*k +: 4]);
  end

  if (AW + 1 >= 4) begin : g_pc_wide
    assign w_pc_nib = r_pc[3:0];
  end else begin : g_pc_narrow
    assign w_pc_nib = {{(3 - AW){1'b0}}, r_pc};
  end

  assign seg_pc = hex7(w_pc_nib);

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Purpose  : Directed self-checking bench for instr_sequencer (default
//            parameters). Covers the hold sequence, free-run, single-step,
//            stall, frozen store, ignored start, async reset, zero length,
//            length clamping and the hex displays.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  localparam int AW = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         mode = 1'b0;
  logic         step = 1'b0;
  logic         start = 1'b0;
  logic [AW:0]  prog_len = '0;
  logic         prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [15:0]  prog_data = '0;
  logic [15:0]  instr;
  logic         instr_valid;
  logic         instr_ready = 1'b0;
  logic         core_rst;
  logic [AW:0]  pc;
  logic         busy;
  logic         done;
  logic [15:0]  alu_in = '0;
  logic [27:0]  seg;
  logic [6:0]   seg_pc;

  int checks = 0;
  int errors = 0;

  instr_sequencer #(
    .INSTR_W (16),
    .DEPTH   (32),
    .DATA_W  (16),
    .HOLD_CYC(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .step       (step),
    .start      (start),
    .prog_len   (prog_len),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .core_rst   (core_rst),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
    .alu_in     (alu_in),
    .seg        (seg),
    .seg_pc     (seg_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic hold_seq(input string tag);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk({tag, "_core_rst"}, 64'(core_rst), (i < 4) ? 64'd1 : 64'd0);
      chk({tag, "_valid"}, 64'(instr_valid), 64'd0);
    end
  endtask

  initial begin
    // ---------------- reset and hold sequence ----------------
    tick(); tick();
    chk("rst_core_rst", 64'(core_rst), 64'd1);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_seg_pc", 64'(seg_pc), 64'b1000000);
    rst = 1'b1;
    hold_seq("hold1");
    chk("idle_busy", 64'(busy), 64'd0);

    // ---------------- free-run, 11 words ----------------
    for (int i = 0; i < 11; i++) wr(AW'(i), 16'h5100);
    mode = 1'b1; instr_ready = 1'b1; prog_len = 6'd11; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      chk("run_pc", 64'(pc), 64'(k));
      chk("run_valid", 64'(instr_valid), 64'd1);
      chk("run_instr", 64'(instr), 64'h5100);
      if (k == 5) chk("run_seg_pc5", 64'(seg_pc), 64'b0010010);
      tick();
    end
    chk("run_done", 64'(done), 64'd1);
    chk("run_end_pc", 64'(pc), 64'd11);
    chk("run_end_instr", 64'(instr), 64'd0);
    chk("run_end_valid", 64'(instr_valid), 64'd0);
    chk("run_seg_pcb", 64'(seg_pc), 64'b0000011);

    // ---------------- single-step, 3 words ----------------
    wr(5'd0, 16'h1111); wr(5'd1, 16'h2222); wr(5'd2, 16'h3333);
    mode = 1'b0; prog_len = 6'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("step_busy", 64'(busy), 64'd1);
    chk("step_wait_valid", 64'(instr_valid), 64'd0);
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      tick(); chk("step_lat1", 64'(instr_valid), 64'd0);
      tick(); chk("step_lat2", 64'(instr_valid), 64'd0);
      tick();
      chk("step_issue_valid", 64'(instr_valid), 64'd1);
      chk("step_issue_pc", 64'(pc), 64'(p));
      chk("step_issue_instr", 64'(instr), 64'(16'h1111 * (p + 1)));
      tick();
      chk("step_after_valid", 64'(instr_valid), 64'd0);
      chk("step_after_pc", 64'(pc), 64'(p + 1));
      chk("step_done", 64'(done), (p == 2) ? 64'd1 : 64'd0);
      step = 1'b0;
      for (int w = 0; w < 6; w++) begin
        tick();
        chk("step_no_extra", 64'(instr_valid), 64'd0);
      end
    end

    // ------- stall, frozen store, ignored start, async reset -------
    for (int i = 0; i < 6; i++) wr(AW'(i), 16'hA000 + 16'(i));
    mode = 1'b1; instr_ready = 1'b1; prog_len = 6'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("stall_pc_entry", 64'(pc), 64'd2);
    instr_ready = 1'b0;
    prog_we = 1'b1; prog_addr = 5'd3; prog_data = 16'hDEAD;
    start = 1'b1; prog_len = 6'd1;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("stall_pc", 64'(pc), 64'd2);
      chk("stall_valid", 64'(instr_valid), 64'd1);
      chk("stall_instr", 64'(instr), 64'hA002);
    end
    prog_we = 1'b0; start = 1'b0; instr_ready = 1'b1;
    tick();
    chk("frozen_pc", 64'(pc), 64'd3);
    chk("frozen_instr", 64'(instr), 64'hA003);
    tick();
    chk("midrun_pc", 64'(pc), 64'd4);
    rst = 1'b0;
    #1;
    chk("async_valid", 64'(instr_valid), 64'd0);
    chk("async_core_rst", 64'(core_rst), 64'd1);
    chk("async_pc", 64'(pc), 64'd0);
    tick();
    rst = 1'b1;
    hold_seq("hold2");

    // ---------------- zero length ----------------
    prog_len = 6'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    chk("zero_valid", 64'(instr_valid), 64'd0);

    // ---------------- length clamp (40 -> 32) ----------------
    prog_len = 6'd40; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k == 0) chk("clamp_instr0_kept", 64'(instr), 64'hA000);
      if (k == 3) chk("clamp_instr3_kept", 64'(instr), 64'hA003);
      tick();
    end
    chk("clamp_done", 64'(done), 64'd1);
    chk("clamp_pc", 64'(pc), 64'd32);

    // ---------------- display ----------------
    alu_in = 16'h1A2F;
    #1;
    chk("seg_1A2F", 64'(seg), 64'({7'b1111001, 7'b0001000, 7'b0100100, 7'b0001110}));
    alu_in = 16'h0000;
    #1;
    chk("seg_0000", 64'(seg), 64'({4{7'b1000000}}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
